// File: rtl/vga_tpg_pkg.sv
// Shared types and constants for the VGA test-pattern generator.
// Imported by the colour sub-module and the top.
package vga_tpg_pkg;

  typedef logic [2:0][7:0] rgb_t;

  typedef enum logic [1:0] {
    PAT_BARS,
    PAT_RAMP,
    PAT_CHECKER,
    PAT_SOLID
  } pattern_e;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  localparam rgb_t BAR_COLOR [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // $clog2 that never yields a zero-width vector
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/vga_tpg_color.sv
// Combinational pixel colour for one (x, y) position
// under the selected test pattern.
module vga_tpg_color
  import vga_tpg_pkg::*;
#(
  parameter int XW = 10,
  parameter int YW = 9,
  parameter int CL = 5
) (
  input  pattern_e         pattern,
  input  logic [XW-1:0]    x,
  input  logic [YW-1:0]    y,
  input  logic [2:0]       bar,
  input  rgb_t             solid,
  output rgb_t             rgb
);

  logic [31:0] xe;
  logic [31:0] ye;
  logic        unused_ok;

  // widened copies keep bit picks legal for any geometry
  assign xe = 32'(x);
  assign ye = 32'(y);
  assign unused_ok = ^{xe, ye};

  always_comb begin
    rgb = '0;
    unique case (pattern)
      PAT_BARS:    rgb = BAR_COLOR[bar];
      PAT_RAMP:    rgb = {3{xe[7:0]}};
      PAT_CHECKER: rgb = (xe[CL] ^ ye[CL]) ? 24'hFFFFFF : 24'h000000;
      PAT_SOLID:   rgb = solid;
      default:     rgb = '0;
    endcase
  end

endmodule

// File: rtl/vga_test_pattern.sv
// AXI4-Stream video test-pattern source: one frame of
// H_ACTIVE x V_ACTIVE pixels, SOF on tuser, EOL on tlast.
module vga_test_pattern
  import vga_tpg_pkg::*;
#(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int CHECKER_LOG2 = 5
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            enable,
  input  logic [1:0]      pattern_sel,
  input  logic [2:0][7:0] solid_rgb,
  output logic            pix_tvalid,
  input  logic            pix_tready,
  output logic [2:0][7:0] pix_tdata,
  output logic            pix_tlast,
  output logic            pix_tuser,
  output logic            busy,
  output logic [15:0]     frame_count
);

  localparam int XW      = $clog2(H_ACTIVE);
  localparam int YW      = clog2_min1(V_ACTIVE);
  localparam int BAR_LEN = H_ACTIVE / 8;
  localparam int BW      = clog2_min1(BAR_LEN);

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BAR_LEN - 1);

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d, nx;
  logic [YW-1:0] y_q, y_d, ny;
  logic [BW-1:0] bcnt_q, bcnt_d, nbcnt;
  logic [2:0]    bar_q, bar_d, nbar;
  pattern_e      pat_q, pat_d, cur_pat;
  rgb_t          solid_q, solid_d, cur_solid;
  rgb_t          tdata_q, tdata_d, nxt_rgb;
  logic          tlast_q, tlast_d;
  logic          tuser_q, tuser_d;
  logic [15:0]   fc_q, fc_d;

  logic beat, x_end, y_end, frame_end, start, adv;

  // next pixel position and the selection it is drawn with
  always_comb begin
    beat      = (state_q == RUN) && pix_tready;
    x_end     = (x_q == X_LAST);
    y_end     = (y_q == Y_LAST);
    frame_end = beat && x_end && y_end;
    start     = enable && ((state_q == IDLE) || frame_end);
    adv       = start || beat;
    nx        = x_q + 1'b1;
    ny        = y_q;
    nbcnt     = bcnt_q + 1'b1;
    nbar      = bar_q;
    if (start) begin
      nx    = '0;
      ny    = '0;
      nbcnt = '0;
      nbar  = '0;
    end else if (x_end) begin
      nx    = '0;
      ny    = y_end ? '0 : y_q + 1'b1;
      nbcnt = '0;
      nbar  = '0;
    end else if (bcnt_q == B_LAST) begin
      nbcnt = '0;
      nbar  = bar_q + 1'b1;
    end
    cur_pat   = start ? pattern_e'(pattern_sel) : pat_q;
    cur_solid = start ? solid_rgb : solid_q;
  end

  vga_tpg_color #(
    .XW (XW),
    .YW (YW),
    .CL (CHECKER_LOG2)
  ) u_color (
    .pattern (cur_pat),
    .x       (nx),
    .y       (ny),
    .bar     (nbar),
    .solid   (cur_solid),
    .rgb     (nxt_rgb)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    bcnt_d  = bcnt_q;
    bar_d   = bar_q;
    pat_d   = pat_q;
    solid_d = solid_q;
    tdata_d = tdata_q;
    tlast_d = tlast_q;
    tuser_d = tuser_q;
    fc_d    = fc_q;
    unique case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN:  if (frame_end && !enable) state_d = IDLE;
    endcase
    // outputs only move on a beat, so they hold through stalls
    if (adv) begin
      x_d     = nx;
      y_d     = ny;
      bcnt_d  = nbcnt;
      bar_d   = nbar;
      tdata_d = nxt_rgb;
      tuser_d = start;
      tlast_d = (nx == X_LAST);
    end
    if (start) begin
      pat_d   = cur_pat;
      solid_d = cur_solid;
    end
    if (frame_end) fc_d = fc_q + 16'd1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      bcnt_q  <= '0;
      bar_q   <= '0;
      pat_q   <= PAT_BARS;
      solid_q <= '0;
      tdata_q <= '0;
      tlast_q <= 1'b0;
      tuser_q <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      bcnt_q  <= bcnt_d;
      bar_q   <= bar_d;
      pat_q   <= pat_d;
      solid_q <= solid_d;
      tdata_q <= tdata_d;
      tlast_q <= tlast_d;
      tuser_q <= tuser_d;
      fc_q    <= fc_d;
    end
  end

  assign pix_tvalid  = (state_q == RUN);
  assign busy        = (state_q == RUN);
  assign pix_tdata   = tdata_q;
  assign pix_tlast   = tlast_q;
  assign pix_tuser   = tuser_q;
  assign frame_count = fc_q;

endmodule
